// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller:
// 16 lines x 4 words x 16 bits with a single-word backing-memory handshake.
module dcache_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_stall,
   output logic        cache_hit,
   output logic        cache_req,
   output logic        cpu_err,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   // state   | meaning
   // IDLE    | waiting for a request; hit/miss looked up on the incoming address
   // COMPARE | hit completes here, miss chooses write-back or fill
   // WB      | writing the four dirty words of the victim line
   // FILL    | reading the four words of the requested line
   // RESP    | miss or error completion; stores merge their word here
   typedef enum logic [2:0] {IDLE, COMPARE, WB, FILL, RESP} stateT;

   stateT       state;
   logic [8:0]  tagArr  [16];
   logic [15:0] dataArr [16][4];
   logic [15:0] validBits;
   logic [15:0] dirtyBits;

   logic [8:0]  reqTag;
   logic [3:0]  reqIdx;
   logic [1:0]  reqWord;
   logic        reqWrite;
   logic [15:0] reqWdata;
   logic        reqHit;
   logic        reqDirty;
   logic        reqErr;
   logic [1:0]  cnt;
   logic [1:0]  cntNext;

   logic        reqValid;
   logic        reqIllegal;
   logic        lookupHit;
   logic [3:0]  lookupIdx;

   logic        arrWe;
   logic        tagWe;
   logic [1:0]  arrWord;
   logic [15:0] arrWdata;

   assign lookupIdx  = cpu_addr[6:3];
   assign reqValid   = (cpu_rd ^ cpu_wr) & ~cpu_addr[0];
   assign reqIllegal = (cpu_rd & cpu_wr) | ((cpu_rd | cpu_wr) & cpu_addr[0]);
   assign lookupHit  = validBits[lookupIdx] & (tagArr[lookupIdx] == cpu_addr[15:7]);
   assign cntNext    = cnt + 2'd1;

   assign cache_req  = (state == IDLE) & reqValid;
   assign cpu_stall  = (state != IDLE) & ~cpu_done;

   always_comb begin
      arrWe    = 1'b0;
      arrWord  = reqWord;
      arrWdata = reqWdata;
      tagWe    = 1'b0;
      case (state)
         COMPARE: arrWe = reqHit & reqWrite;
         FILL: begin
            if (mem_ack) begin
               arrWe    = 1'b1;
               arrWord  = cnt;
               arrWdata = mem_rdata;
               tagWe    = (cnt == 2'd3);
            end
         end
         RESP:    arrWe = reqWrite & ~reqErr;
         default: arrWe = 1'b0;
      endcase
   end

   // Data and tag storage carry no reset; validBits gates every use.
   always_ff @(posedge clk) begin
      if (arrWe) dataArr[reqIdx][arrWord] <= arrWdata;
      if (tagWe) tagArr[reqIdx] <= reqTag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         validBits <= '0;
         dirtyBits <= '0;
         reqTag    <= '0;
         reqIdx    <= '0;
         reqWord   <= '0;
         reqWrite  <= 1'b0;
         reqWdata  <= '0;
         reqHit    <= 1'b0;
         reqDirty  <= 1'b0;
         reqErr    <= 1'b0;
         cnt       <= '0;
         cpu_rdata <= '0;
         cpu_done  <= 1'b0;
         cache_hit <= 1'b0;
         cpu_err   <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         cpu_done  <= 1'b0;
         cache_hit <= 1'b0;
         cpu_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (reqValid) begin
                  reqTag   <= cpu_addr[15:7];
                  reqIdx   <= lookupIdx;
                  reqWord  <= cpu_addr[2:1];
                  reqWrite <= cpu_wr;
                  reqWdata <= cpu_wdata;
                  reqHit   <= lookupHit;
                  reqDirty <= dirtyBits[lookupIdx] & validBits[lookupIdx];
                  reqErr   <= 1'b0;
                  if (lookupHit) begin
                     // Hit completes in COMPARE, so its response is staged now.
                     cpu_done  <= 1'b1;
                     cache_hit <= 1'b1;
                     cpu_rdata <= cpu_wr ? 16'h0000 : dataArr[lookupIdx][cpu_addr[2:1]];
                  end
                  state <= COMPARE;
               end else if (reqIllegal) begin
                  reqErr    <= 1'b1;
                  cpu_done  <= 1'b1;
                  cpu_err   <= 1'b1;
                  cpu_rdata <= 16'h0000;
                  state     <= RESP;
               end
            end
            COMPARE: begin
               cnt <= 2'd0;
               if (reqHit) begin
                  if (reqWrite) dirtyBits[reqIdx] <= 1'b1;
                  state <= IDLE;
               end else if (reqDirty) begin
                  mem_wr    <= 1'b1;
                  mem_addr  <= {tagArr[reqIdx], reqIdx, 2'd0, 1'b0};
                  mem_wdata <= dataArr[reqIdx][0];
                  state     <= WB;
               end else begin
                  mem_rd   <= 1'b1;
                  mem_addr <= {reqTag, reqIdx, 2'd0, 1'b0};
                  state    <= FILL;
               end
            end
            WB: begin
               if (mem_ack) begin
                  if (cnt == 2'd3) begin
                     cnt      <= 2'd0;
                     mem_wr   <= 1'b0;
                     mem_rd   <= 1'b1;
                     mem_addr <= {reqTag, reqIdx, 2'd0, 1'b0};
                     state    <= FILL;
                  end else begin
                     cnt       <= cntNext;
                     mem_addr  <= {tagArr[reqIdx], reqIdx, cntNext, 1'b0};
                     mem_wdata <= dataArr[reqIdx][cntNext];
                  end
               end
            end
            FILL: begin
               if (mem_ack) begin
                  if (cnt == 2'd3) begin
                     cnt               <= 2'd0;
                     mem_rd            <= 1'b0;
                     validBits[reqIdx] <= 1'b1;
                     dirtyBits[reqIdx] <= 1'b0;
                     cpu_done          <= 1'b1;
                     if (reqWrite)
                        cpu_rdata <= 16'h0000;
                     else if (reqWord == cnt)
                        cpu_rdata <= mem_rdata;
                     else
                        cpu_rdata <= dataArr[reqIdx][reqWord];
                     state <= RESP;
                  end else begin
                     cnt      <= cntNext;
                     mem_addr <= {reqTag, reqIdx, cntNext, 1'b0};
                  end
               end
            end
            RESP: begin
               if (reqWrite && !reqErr) dirtyBits[reqIdx] <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a line-level cache model and a latency-programmable
// backing memory, driven by directed scenarios followed by random traffic.
module tb_dcache_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_rd, cpu_wr;
   logic [15:0] cpu_addr, cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_done, cpu_stall, cache_hit, cache_req, cpu_err;
   logic        mem_rd, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = 16'h0000;
   logic        mem_ack = 1'b0;

   always #5 clk = ~clk;

   dcache_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
      .cache_hit(cache_hit), .cache_req(cache_req), .cpu_err(cpu_err),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   int checks = 0;
   int failures = 0;
   int memLat = 0;
   int waitCnt = 0;

   logic [15:0] mem    [32768];
   logic [15:0] refMem [32768];
   logic [15:0] xAddr[$];
   logic        xWr[$];
   logic [15:0] xData[$];

   // cache model: what each line holds, independent of controller sequencing
   logic [15:0] mValid, mDirty;
   logic [8:0]  mTag  [16];
   logic [15:0] mData [16][4];

   logic [15:0] lastRdata;
   logic        lastHit, lastErr;
   int          lastCycles;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // backing memory: acks after memLat idle strobe cycles, random acks when not strobed
   always @(negedge clk) begin
      if (mem_rd || mem_wr) begin
         if (waitCnt >= memLat) begin
            mem_ack = 1'b1;
            waitCnt = 0;
            xAddr.push_back(mem_addr);
            xWr.push_back(mem_wr);
            if (mem_wr) begin
               mem[mem_addr[15:1]] = mem_wdata;
               xData.push_back(mem_wdata);
            end else begin
               mem_rdata = mem[mem_addr[15:1]];
               xData.push_back(mem_rdata);
            end
         end else begin
            mem_ack = 1'b0;
            waitCnt++;
         end
      end else begin
         mem_ack   = ($urandom_range(3) == 0);
         mem_rdata = 16'($urandom);
         waitCnt   = 0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("strobe_exclusive", 32'(mem_rd & mem_wr), 32'(0));
         if (!cpu_stall) chk("strobe_when_not_busy", 32'(mem_rd | mem_wr), 32'(0));
      end
   end

   task automatic doReq(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
      logic        legal, hit;
      logic [3:0]  idx;
      logic [8:0]  tag;
      logic [1:0]  w;
      logic [15:0] a, expRd;
      logic [15:0] eA[$];
      logic        eW[$];
      logic [15:0] eD[$];
      int          expCyc, cyc, n;
      bit          seen;
      legal = (rd ^ wr) && !addr[0];
      idx   = addr[6:3];
      tag   = addr[15:7];
      w     = addr[2:1];
      hit   = legal && mValid[idx] && (mTag[idx] == tag);
      expRd = 16'h0000;
      if (legal && !hit) begin
         if (mDirty[idx]) begin
            for (int i = 0; i < 4; i++) begin
               a = {mTag[idx], idx, 2'(i), 1'b0};
               eA.push_back(a); eW.push_back(1'b1); eD.push_back(mData[idx][i]);
               refMem[a[15:1]] = mData[idx][i];
            end
         end
         for (int i = 0; i < 4; i++) begin
            a = {tag, idx, 2'(i), 1'b0};
            eA.push_back(a); eW.push_back(1'b0); eD.push_back(refMem[a[15:1]]);
            mData[idx][i] = refMem[a[15:1]];
         end
         mValid[idx] = 1'b1; mTag[idx] = tag; mDirty[idx] = 1'b0;
      end
      if (legal) begin
         if (rd) expRd = mData[idx][w];
         else begin mData[idx][w] = wdata; mDirty[idx] = 1'b1; end
      end
      // one COMPARE cycle, (memLat+1) cycles per word, then RESP
      expCyc = (legal && !hit) ? 2 + eA.size() * (memLat + 1) : 1;
      xAddr.delete(); xWr.delete(); xData.delete();

      @(negedge clk);
      cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
      #1 chk("cache_req_accept", 32'(cache_req), 32'(legal));
      cyc = 0; seen = 0;
      while (!seen && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (cpu_done) begin
            seen = 1;
            cpu_rd = 1'b0; cpu_wr = 1'b0;
         end else begin
            cpu_rd = 1'($urandom); cpu_wr = 1'($urandom); cpu_addr = 16'($urandom);
            #1 chk("cache_req_busy", 32'(cache_req), 32'(0));
         end
      end
      chk("done_seen", 32'(seen), 32'(1));
      chk("done_latency", 32'(cyc), 32'(expCyc));
      chk("cache_hit", 32'(cache_hit), 32'(hit));
      chk("cpu_err", 32'(cpu_err), 32'(!legal));
      if (!legal || rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(expRd));
      chk("xfer_count", 32'(xAddr.size()), 32'(eA.size()));
      n = (xAddr.size() < eA.size()) ? xAddr.size() : eA.size();
      for (int i = 0; i < n; i++) begin
         chk("xfer_addr", 32'(xAddr[i]), 32'(eA[i]));
         chk("xfer_dir", 32'(xWr[i]), 32'(eW[i]));
         if (eW[i]) chk("xfer_wdata", 32'(xData[i]), 32'(eD[i]));
      end
      lastRdata = cpu_rdata; lastHit = cache_hit; lastErr = cpu_err; lastCycles = cyc;
      @(negedge clk);
      chk("done_single_pulse", 32'({cpu_done, cache_hit, cpu_err}), 32'(0));
      chk("idle_not_stalled", 32'(cpu_stall), 32'(0));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run did not complete, actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int cyc;
      int op, tsel;
      logic [15:0] ra;
      rst_n = 1'b0;
      cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
      for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 16'h01F3) ^ 16'h5A5A;
      mem[16'h0020] = 16'h1234;
      mem[16'h0062] = 16'hC0DE;
      refMem = mem;
      mValid = '0; mDirty = '0;

      #12;
      chk("reset_outputs", 32'({cpu_done, cpu_stall, cache_hit, cache_req, cpu_err, mem_rd, mem_wr}), 32'(0));
      chk("reset_rdata", 32'(cpu_rdata), 32'(0));
      chk("reset_mem_addr", 32'(mem_addr), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      memLat = 0;
      doReq(1'b1, 1'b0, 16'h0040, 16'h0000);
      chk("lit_miss_rdata", 32'(lastRdata), 32'h1234);
      chk("lit_miss_hit", 32'(lastHit), 32'(0));
      chk("lit_miss_reads", 32'(xAddr.size()), 32'(4));
      for (int i = 0; i < 4 && i < xAddr.size(); i++)
         chk("lit_fill_addr", 32'(xAddr[i]), 32'(16'h0040 + 2 * i));

      doReq(1'b1, 1'b0, 16'h0042, 16'h0000);
      chk("lit_hit_flag", 32'(lastHit), 32'(1));
      chk("lit_hit_latency", 32'(lastCycles), 32'(1));
      chk("lit_hit_no_mem", 32'(xAddr.size()), 32'(0));

      doReq(1'b0, 1'b1, 16'h0044, 16'hBEEF);
      chk("lit_store_hit", 32'(lastHit), 32'(1));

      memLat = 5;
      doReq(1'b1, 1'b0, 16'h00C4, 16'h0000);
      chk("lit_evict_xfers", 32'(xAddr.size()), 32'(8));
      if (xAddr.size() == 8) begin
         chk("lit_wb_addr", 32'(xAddr[2]), 32'h0044);
         chk("lit_wb_data", 32'(xData[2]), 32'hBEEF);
         chk("lit_wb_dir", 32'(xWr[2]), 32'(1));
         chk("lit_fill_first", 32'(xAddr[4]), 32'h00C0);
         chk("lit_fill_dir", 32'(xWr[4]), 32'(0));
      end
      chk("lit_evict_rdata", 32'(lastRdata), 32'hC0DE);
      chk("lit_evict_latency", 32'(lastCycles), 32'(50));

      memLat = 0;
      doReq(1'b1, 1'b0, 16'h0041, 16'h0000);
      chk("lit_err_odd", 32'(lastErr), 32'(1));
      doReq(1'b1, 1'b1, 16'h0040, 16'h0000);
      chk("lit_err_both", 32'(lastErr), 32'(1));
      chk("lit_err_no_mem", 32'(xAddr.size()), 32'(0));

      // reset while word 2 of a fill is outstanding
      memLat = 3;
      xAddr.delete(); xWr.delete(); xData.delete();
      @(negedge clk);
      cpu_rd = 1'b1; cpu_addr = 16'h0040;
      @(negedge clk);
      cpu_rd = 1'b0;
      cyc = 0;
      while (xAddr.size() != 2 && cyc < 100) begin
         @(posedge clk);
         cyc++;
      end
      chk("fill_reached_word2", 32'(xAddr.size()), 32'(2));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mem_rd_drop", 32'(mem_rd), 32'(0));
      chk("rst_outputs", 32'({cpu_done, cpu_stall, cpu_err, mem_wr}), 32'(0));
      mValid = '0; mDirty = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      memLat = 1;
      doReq(1'b1, 1'b0, 16'h0040, 16'h0000);
      chk("lit_post_reset_miss", 32'(lastHit), 32'(0));
      chk("lit_post_reset_reads", 32'(xAddr.size()), 32'(4));
      chk("lit_post_reset_rdata", 32'(lastRdata), 32'h1234);

      for (int k = 0; k < 400; k++) begin
         tsel = $urandom_range(3);
         ra = {7'd0, 2'(tsel), 4'($urandom_range(15)), 2'($urandom_range(3)),
               1'($urandom_range(15) == 0)};
         op = $urandom_range(19);
         memLat = $urandom_range(5);
         if (op < 9)       doReq(1'b1, 1'b0, ra, 16'($urandom));
         else if (op < 18) doReq(1'b0, 1'b1, ra, 16'($urandom));
         else              doReq(1'b1, 1'b1, ra, 16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
